// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: ADD/SUB/AND/OR, one bit per clock, LSB first.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow output.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       alu_ctrl,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_c;
  logic               last_c;
  logic               arith_c;
  logic               bit_c;
  logic               carry_d;
  logic [WIDTH-1:0]   res_next_c;

  assign accept_c = (state_q == IDLE) && start_valid;
  assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));
  assign arith_c  = ~op_q[1];

  // One-bit slice plus the inter-bit carry it lacks.
  always_comb begin
    bit_c   = 1'b0;
    carry_d = carry_q;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        bit_c   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
      end
      OP_AND: bit_c = a_q[0] & b_q[0];
      OP_OR:  bit_c = a_q[0] | b_q[0];
      default: bit_c = 1'b0;
    endcase
    res_next_c = {bit_c, res[WIDTH-1:1]};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_c)      state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and handshake outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_ready <= (state_d == IDLE);
      busy        <= (state_d == RUN);
      res_valid   <= (state_d == DONE);
    end
  end

  // Operand shifters, carry, bit counter and result shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      res       <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (accept_c) begin
      a_q     <= op_a;
      b_q     <= (alu_ctrl == OP_SUB) ? ~op_b : op_b;
      op_q    <= alu_ctrl;
      carry_q <= ~alu_ctrl[1] & alu_ctrl[0];
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_d;
      res     <= res_next_c;
      cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
      if (last_c) begin
        carry_out <= arith_c & carry_d;
        zero      <= (res_next_c == '0);
      end
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if ((state_q == RUN) && last_c) begin
      overflow <= arith_c & (carry_q ^ carry_d);
    end
  end
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed self-checking bench for serial_alu_seq (WIDTH=8).
module tb_serial_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   alu_ctrl;
  logic         busy, res_valid, res_ready;
  logic [W-1:0] res;
  logic         carry_out, zero;
`ifdef SERIAL_ALU_OVF_EN
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .carry_out(carry_out), .zero(zero)
`ifdef SERIAL_ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ctrl;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_z;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait in IDLE for start_ready, present the request for one edge, then scramble inputs.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    int n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready_wait", 32'(start_ready), 32'd1);
    op_a = a; op_b = b; alu_ctrl = c; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    op_a = ~a; op_b = 8'h5C; alu_ctrl = ~c;
  endtask

  // Count cycles from the accept edge until res_valid.
  task automatic wait_res(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int first_acc, second_acc, now;

    vecs[0] = '{8'h5A, 8'h33, 2'b00, 8'h8D, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 2'b01, 8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hF0, 8'h0F, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{8'h0F, 8'hF0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'hFF, 8'hFF, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0; alu_ctrl = '0;
    repeat (3) @(negedge clk);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_flags", 32'({carry_out, zero}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].ctrl);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_start_ready", 32'(start_ready), 32'd0);
      wait_res(cyc);
      chk("latency", 32'(cyc), 32'(W));
      chk("res", 32'(res), 32'(vecs[i].exp_res));
      chk("carry_out", 32'(carry_out), 32'(vecs[i].exp_c));
      chk("zero", 32'(zero), 32'(vecs[i].exp_z));
`ifdef SERIAL_ALU_OVF_EN
      chk("overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
`endif
      chk("done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_to_idle", 32'(start_ready), 32'd1);
    end

    // Back-pressure in DONE with start_valid pulsing.
    res_ready = 1'b0;
    start_op(8'h5A, 8'h33, 2'b00);
    wait_res(cyc);
    for (int k = 0; k < 5; k++) begin
      start_valid = k[0] ? 1'b0 : 1'b1;
      op_a = 8'(k); op_b = 8'h11; alu_ctrl = 2'b11;
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk("bp_res", 32'(res), 32'h8D);
      chk("bp_flags", 32'({carry_out, zero}), 32'd0);
    end
    // Consume with start_valid high in the same DONE cycle: start must not be taken.
    start_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_release_ready", 32'(start_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("idle_res_hold", 32'(res), 32'h8D);
    @(negedge clk);
    chk("no_accept_busy", 32'(busy), 32'd0);

    // Reset while processing bit 3.
    start_op(8'hA5, 8'h0F, 2'b00);
    repeat (3) @(negedge clk);
    chk("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_flags", 32'({carry_out, zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(start_ready), 32'd1);
    start_op(8'h20, 8'h05, 2'b01);
    wait_res(cyc);
    chk("post_rst_latency", 32'(cyc), 32'(W));
    chk("post_rst_res", 32'(res), 32'h1B);
    chk("post_rst_carry", 32'(carry_out), 32'd1);
    @(negedge clk);

    // Back-to-back with both handshakes held high.
    first_acc = -1; second_acc = -1;
    op_a = 8'h01; op_b = 8'h02; alu_ctrl = 2'b00;
    start_valid = 1'b1; res_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      now = t;
      if (start_ready && start_valid) begin
        if (first_acc < 0) first_acc = now;
        else if (second_acc < 0) second_acc = now;
      end
      if (res_valid) chk("b2b_res", 32'(res), 32'h03);
      @(negedge clk);
    end
    start_valid = 1'b0;
    chk("b2b_first_seen", 32'(first_acc >= 0), 32'd1);
    chk("b2b_period", 32'(second_acc - first_acc), 32'(W + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
